// File: rtl/l1_miss_controller.sv
// Miss-handling FSM for a 2-way L1 cache backed by a victim cache.
// Array strobes are decoded from the current state plus request inputs so hits finish in one cycle.
module l1_miss_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        hit,
    input  logic        way_hit,
    input  logic        lru_way,
    input  logic        lru_valid,
    input  logic        lru_dirty,
    input  logic        lower_resp,
    output logic        mem_resp,
    output logic        lower_read,
    output logic        lower_write,
    output logic        evict_dirty,
    output logic [1:0]  data_load,
    output logic [1:0]  tag_load,
    output logic [1:0]  valid_load,
    output logic [1:0]  dirty_load,
    output logic        dirty_in,
    output logic        lru_load,
    output logic        lru_in,
    output logic        datain_sel,
    output logic        addr_sel,
    output logic [15:0] miss_count,
    output logic [15:0] evict_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_lru_way;
    logic        r_evict_dirty;
    logic [15:0] r_miss_count;
    logic [15:0] r_evict_count;

    logic        w_req;
    logic [1:0]  w_hit_mask;
    logic [1:0]  w_fill_mask;

    assign w_req       = mem_read | mem_write;
    assign w_hit_mask  = way_hit   ? 2'b10 : 2'b01;
    assign w_fill_mask = r_lru_way ? 2'b10 : 2'b01;
    assign miss_count  = r_miss_count;
    assign evict_count = r_evict_count;

    // Victim way and dirty flag are captured on IDLE exit so the lookup inputs may change mid-miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lru_way     <= 1'b0;
            r_evict_dirty <= 1'b0;
            r_miss_count  <= 16'h0000;
            r_evict_count <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !hit) begin
                        r_miss_count  <= r_miss_count + 16'h0001;
                        r_lru_way     <= lru_way;
                        r_evict_dirty <= lru_dirty;
                        r_state       <= lru_valid ? EVICT : FILL;
                    end
                end
                EVICT: begin
                    if (lower_resp) begin
                        r_evict_count <= r_evict_count + 16'h0001;
                        r_state       <= FILL;
                    end
                end
                FILL: begin
                    if (lower_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // All strobes are gated by rst so an abandoned transaction never writes the arrays.
    always_comb begin
        mem_resp    = 1'b0;
        lower_read  = 1'b0;
        lower_write = 1'b0;
        evict_dirty = 1'b0;
        data_load   = 2'b00;
        tag_load    = 2'b00;
        valid_load  = 2'b00;
        dirty_load  = 2'b00;
        dirty_in    = 1'b0;
        lru_load    = 1'b0;
        lru_in      = 1'b0;
        datain_sel  = 1'b0;
        addr_sel    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_req && hit) begin
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        lru_in   = ~way_hit;
                        if (mem_write) begin
                            data_load  = w_hit_mask;
                            dirty_load = w_hit_mask;
                            dirty_in   = 1'b1;
                        end
                    end
                end
                EVICT: begin
                    lower_write = 1'b1;
                    addr_sel    = 1'b1;
                    evict_dirty = r_evict_dirty;
                end
                FILL: begin
                    lower_read = 1'b1;
                    if (lower_resp) begin
                        data_load  = w_fill_mask;
                        tag_load   = w_fill_mask;
                        valid_load = w_fill_mask;
                        dirty_load = w_fill_mask;
                        datain_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_miss_controller.sv
// Randomized bench for l1_miss_controller: a transaction-level model expands each CPU request
// into its expected per-cycle output pattern and tracks the performance counters.
module tb_l1_miss_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mem_read, mem_write, hit, way_hit, lru_way, lru_valid, lru_dirty, lower_resp;
    logic mem_resp, lower_read, lower_write, evict_dirty;
    logic [1:0] data_load, tag_load, valid_load, dirty_load;
    logic dirty_in, lru_load, lru_in, datain_sel, addr_sel;
    logic [15:0] miss_count, evict_count;

    l1_miss_controller dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .way_hit(way_hit), .lru_way(lru_way), .lru_valid(lru_valid), .lru_dirty(lru_dirty),
        .lower_resp(lower_resp), .mem_resp(mem_resp), .lower_read(lower_read),
        .lower_write(lower_write), .evict_dirty(evict_dirty), .data_load(data_load),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_in(dirty_in), .lru_load(lru_load), .lru_in(lru_in), .datain_sel(datain_sel),
        .addr_sel(addr_sel), .miss_count(miss_count), .evict_count(evict_count)
    );

    typedef struct packed {
        logic       mem_resp, lower_read, lower_write, evict_dirty;
        logic [1:0] data_load, tag_load, valid_load, dirty_load;
        logic       dirty_in, lru_load, lru_in, datain_sel, addr_sel;
    } outs_t;

    outs_t obs;
    assign obs = {mem_resp, lower_read, lower_write, evict_dirty, data_load, tag_load,
                  valid_load, dirty_load, dirty_in, lru_load, lru_in, datain_sel, addr_sel};

    localparam int K_QUIET = 0, K_HIT_RD = 1, K_HIT_WR = 2, K_EVICT = 3, K_FILL_WAIT = 4, K_FILL_DONE = 5;

    int checks = 0;
    int errors = 0;
    int m_miss = 0;
    int m_evict = 0;

    // Expected outputs (e) and which of them matter (m) for one cycle of a given kind.
    function automatic void model(input int kind, input logic way, input logic d,
                                  output outs_t e, output outs_t m);
        logic [1:0] wm;
        wm = way ? 2'b10 : 2'b01;
        e = '0;
        m = '0;
        m.mem_resp = 1'b1; m.lower_read = 1'b1; m.lower_write = 1'b1; m.lru_load = 1'b1;
        m.data_load = 2'b11; m.tag_load = 2'b11; m.valid_load = 2'b11; m.dirty_load = 2'b11;
        case (kind)
            K_HIT_RD: begin
                e.mem_resp = 1'b1; e.lru_load = 1'b1; e.lru_in = ~way; m.lru_in = 1'b1;
            end
            K_HIT_WR: begin
                e.mem_resp = 1'b1; e.lru_load = 1'b1; e.lru_in = ~way; m.lru_in = 1'b1;
                e.data_load = wm; e.dirty_load = wm; e.dirty_in = 1'b1; e.datain_sel = 1'b0;
                m.dirty_in = 1'b1; m.datain_sel = 1'b1;
            end
            K_EVICT: begin
                e.lower_write = 1'b1; e.evict_dirty = d; e.addr_sel = 1'b1;
                m.evict_dirty = 1'b1; m.addr_sel = 1'b1;
            end
            K_FILL_WAIT: begin
                e.lower_read = 1'b1; m.addr_sel = 1'b1;
            end
            K_FILL_DONE: begin
                e.lower_read = 1'b1; m.addr_sel = 1'b1;
                e.data_load = wm; e.tag_load = wm; e.valid_load = wm; e.dirty_load = wm;
                e.dirty_in = 1'b0; e.datain_sel = 1'b1; m.dirty_in = 1'b1; m.datain_sel = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input logic r, input logic rd, input logic wr, input logic h,
                         input logic wh, input logic lresp);
        rst = r; mem_read = rd; mem_write = wr; hit = h; way_hit = wh; lower_resp = lresp;
        lru_way = 1'($urandom); lru_valid = 1'($urandom); lru_dirty = 1'($urandom);
    endtask

    task automatic test_reset();
        outs_t e, m;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'($urandom), 1'b1);
        #1;
        model(K_QUIET, 1'b0, 1'b0, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", obs & m, e & m);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_miss = 0; m_evict = 0;
        #1;
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL post_reset_outputs: got %h want %h", obs & m, e & m);
        end
        checks++;
        if (miss_count !== m_miss[15:0] || evict_count !== m_evict[15:0]) begin
            errors++; $display("FAIL reset_counters: got %h/%h want %h/%h",
                               miss_count, evict_count, m_miss[15:0], m_evict[15:0]);
        end
    endtask

    task automatic test_hit(input logic rd, input logic wr, input logic wh, input string name);
        outs_t e, m;
        @(posedge clk); #1;
        drive(1'b0, rd, wr, 1'b1, wh, 1'($urandom));
        #1;
        model(wr ? K_HIT_WR : K_HIT_RD, wh, 1'b0, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL %s: got %h want %h", name, obs & m, e & m);
        end
        checks++;
        if (miss_count !== m_miss[15:0] || evict_count !== m_evict[15:0]) begin
            errors++; $display("FAIL %s_counters: got %h/%h want %h/%h", name,
                               miss_count, evict_count, m_miss[15:0], m_evict[15:0]);
        end
    endtask

    task automatic test_read_hit();
        test_hit(1'b1, 1'b0, 1'b1, "read_hit_way1");
        test_hit(1'b1, 1'b0, 1'b0, "read_hit_way0");
    endtask

    task automatic test_write_hit();
        test_hit(1'b0, 1'b1, 1'b0, "write_hit_way0");
        test_hit(1'b0, 1'b1, 1'b1, "write_hit_way1");
        test_hit(1'b1, 1'b1, 1'b0, "rdwr_hit_way0");
        test_hit(1'b1, 1'b1, 1'b1, "rdwr_hit_way1");
    endtask

    // One full miss: lookup cycle, optional eviction, fill, then the re-evaluated request.
    task automatic test_miss(input logic rd, input logic wr, input logic valid, input logic dirty,
                             input logic way, input int ewait, input int fwait, input logic drop,
                             input string name);
        outs_t e, m;
        @(posedge clk); #1;
        drive(1'b0, rd, wr, 1'b0, 1'($urandom), 1'($urandom));
        lru_valid = valid; lru_dirty = dirty; lru_way = way;
        #1;
        model(K_QUIET, 1'b0, 1'b0, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL %s_lookup: got %h want %h", name, obs & m, e & m);
        end
        m_miss++;
        if (valid) begin
            for (int i = 0; i <= ewait; i++) begin
                @(posedge clk); #1;
                drive(1'b0, drop ? 1'b0 : rd, drop ? 1'b0 : wr, 1'($urandom), 1'($urandom), i == ewait);
                #1;
                model(K_EVICT, 1'b0, dirty, e, m);
                checks++;
                if ((obs & m) !== (e & m)) begin
                    errors++; $display("FAIL %s_evict%0d: got %h want %h", name, i, obs & m, e & m);
                end
            end
            m_evict++;
        end
        for (int i = 0; i <= fwait; i++) begin
            @(posedge clk); #1;
            drive(1'b0, drop ? 1'b0 : rd, drop ? 1'b0 : wr, 1'($urandom), 1'($urandom), i == fwait);
            #1;
            model((i == fwait) ? K_FILL_DONE : K_FILL_WAIT, way, 1'b0, e, m);
            checks++;
            if ((obs & m) !== (e & m)) begin
                errors++; $display("FAIL %s_fill%0d: got %h want %h", name, i, obs & m, e & m);
            end
        end
        @(posedge clk); #1;
        drive(1'b0, drop ? 1'b0 : rd, drop ? 1'b0 : wr, ~drop, way, 1'($urandom));
        #1;
        model(drop ? K_QUIET : (wr ? K_HIT_WR : K_HIT_RD), way, 1'b0, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL %s_complete: got %h want %h", name, obs & m, e & m);
        end
        checks++;
        if (miss_count !== m_miss[15:0] || evict_count !== m_evict[15:0]) begin
            errors++; $display("FAIL %s_counters: got %h/%h want %h/%h", name,
                               miss_count, evict_count, m_miss[15:0], m_evict[15:0]);
        end
    endtask

    task automatic test_clean_miss();
        test_miss(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0, "clean_miss");
    endtask

    task automatic test_dirty_evict();
        test_miss(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, "dirty_evict");
        test_miss(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, "clean_evict_write");
        test_miss(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 1'b1, "dropped_miss");
    endtask

    task automatic test_random();
        outs_t e, m;
        for (int t = 0; t < 60; t++) begin
            int sel;
            int rw;
            sel = $urandom_range(0, 3);
            rw  = $urandom_range(0, 2);
            if (sel == 0) begin
                @(posedge clk); #1;
                drive(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                #1;
                model(K_QUIET, 1'b0, 1'b0, e, m);
                checks++;
                if ((obs & m) !== (e & m)) begin
                    errors++; $display("FAIL rand_idle%0d: got %h want %h", t, obs & m, e & m);
                end
            end else if (sel == 1) begin
                test_hit(rw != 1, rw != 0, 1'($urandom), "rand_hit");
            end else begin
                test_miss(rw != 1, rw != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3) == 0, "rand_miss");
            end
        end
    endtask

    task automatic test_rst_mid_miss(input logic in_evict);
        outs_t e, m;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lru_valid = in_evict; lru_dirty = 1'b1; lru_way = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        model(in_evict ? K_EVICT : K_FILL_WAIT, 1'b1, 1'b1, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL rst_mid_%0d_busy: got %h want %h", in_evict, obs & m, e & m);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        model(K_QUIET, 1'b0, 1'b0, e, m);
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL rst_mid_%0d_rstcyc: got %h want %h", in_evict, obs & m, e & m);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_miss = 0; m_evict = 0;
        #1;
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL rst_mid_%0d_after: got %h want %h", in_evict, obs & m, e & m);
        end
        checks++;
        if (miss_count !== m_miss[15:0] || evict_count !== m_evict[15:0]) begin
            errors++; $display("FAIL rst_mid_%0d_counters: got %h/%h want %h/%h", in_evict,
                               miss_count, evict_count, m_miss[15:0], m_evict[15:0]);
        end
        test_hit(1'b1, 1'b0, 1'b0, "rst_mid_then_hit");
    endtask

    task automatic test_counter_wrap();
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        lru_valid = 1'b0;
        m_miss = 0; m_evict = 0;
        repeat (2 * 65535) @(posedge clk);
        #1;
        m_miss += 65535;
        checks++;
        if (miss_count !== m_miss[15:0]) begin
            errors++; $display("FAIL wrap_preload: got %h want %h", miss_count, m_miss[15:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        m_miss += 1;
        checks++;
        if (miss_count !== m_miss[15:0] || evict_count !== m_evict[15:0]) begin
            errors++; $display("FAIL wrap_rollover: got %h/%h want %h/%h",
                               miss_count, evict_count, m_miss[15:0], m_evict[15:0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; way_hit = 1'b0;
        lru_way = 1'b0; lru_valid = 1'b0; lru_dirty = 1'b0; lower_resp = 1'b0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_evict();
        test_random();
        test_rst_mid_miss(1'b0);
        test_rst_mid_miss(1'b1);
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
